// File: rtl/exu_branch_pkg.sv
// Shared encodings for the execute-stage branch unit: condition opcodes,
// FSM states and the flush-count width.
package exu_branch_pkg;

   typedef enum logic [2:0] {
      OP_BEQ  = 3'b000,
      OP_BNE  = 3'b001,
      OP_BLT  = 3'b100,
      OP_BGE  = 3'b101,
      OP_BLTU = 3'b110,
      OP_BGEU = 3'b111
   } br_op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_CMP,
      S_RESOLVE
   } br_state_e;

   localparam int FLUSH_W = 3;

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch-condition evaluator; opcodes 010/011 flag illegal
// and never report taken.
module branch_cmp
   import exu_branch_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_a,
   input  logic [XLEN-1:0] i_b,
   output logic            o_taken,
   output logic            o_illegal
);

   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      o_taken   = 1'b0;
      o_illegal = 1'b0;
      case (i_op)
         OP_BEQ:  o_taken = (i_a == i_b);
         OP_BNE:  o_taken = (i_a != i_b);
         OP_BLT:  o_taken = ($signed(i_a) <  $signed(i_b));
         OP_BGE:  o_taken = ($signed(i_a) >= $signed(i_b));
         OP_BLTU: o_taken = (i_a <  i_b);
         OP_BGEU: o_taken = (i_a >= i_b);
         default: o_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/exu_branch_unit.sv
// Multi-cycle conditional branch unit: read operands, compare, resolve redirect/flush.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined.
module exu_branch_unit
   import exu_branch_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int PC_OFFSET = 8,
   parameter int FLUSH_MAX = 2
) (
   input  logic               hclk,
   input  logic               hrstn,
   input  logic               i_start,
   input  logic [2:0]         i_op,
   input  logic [12:0]        i_imm,
   input  logic [4:0]         i_rs1,
   input  logic [4:0]         i_rs2,
   input  logic [XLEN-1:0]    i_pc,
   output logic               o_reg_ren_1,
   output logic               o_reg_ren_2,
   output logic [4:0]         o_reg_raddr_1,
   output logic [4:0]         o_reg_raddr_2,
   input  logic [XLEN-1:0]    i_reg_rdata_1,
   input  logic [XLEN-1:0]    i_reg_rdata_2,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_pc_write,
   output logic [XLEN-1:0]    o_pc_wdata,
   output logic [FLUSH_W-1:0] o_flush_cnt,
   output logic               o_illegal_op,
   output logic               o_misalign,
   output logic [31:0]        o_taken_cnt,
   output logic [31:0]        o_not_taken_cnt
);

   br_state_e       r_state, w_next_state;
   logic [2:0]      r_op;
   logic [12:0]     r_imm;
   logic [4:0]      r_rs1, r_rs2;
   logic [XLEN-1:0] r_pc_real, r_target;
   logic            r_taken, r_illegal;

   logic            w_cmp_taken, w_cmp_illegal;
   logic [XLEN-1:0] w_imm_sext, w_dist;
   logic            w_near, w_misalign;

   branch_cmp #(.XLEN(XLEN)) u_cmp (
      .i_op      (r_op),
      .i_a       (i_reg_rdata_1),
      .i_b       (i_reg_rdata_2),
      .o_taken   (w_cmp_taken),
      .o_illegal (w_cmp_illegal)
   );

   assign w_imm_sext = {{(XLEN-13){r_imm[12]}}, r_imm};
   assign w_dist     = r_target - r_pc_real;
   assign w_misalign = r_taken & r_target[1];
   // Short forward hops land inside the already-fetched window: flush only, no redirect.
   assign w_near     = (w_dist[1:0] == 2'b00) && (w_dist != '0) &&
                       (w_dist <= XLEN'(4 * FLUSH_MAX));

   always_ff @(posedge hclk or negedge hrstn) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!hrstn) r_state <= S_IDLE;
      else        r_state <= w_next_state;
   end

   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         r_op      <= '0;
         r_imm     <= '0;
         r_rs1     <= '0;
         r_rs2     <= '0;
         r_pc_real <= '0;
         r_target  <= '0;
         r_taken   <= 1'b0;
         r_illegal <= 1'b0;
      end else begin
         if (r_state == S_IDLE && i_start) begin
            r_op      <= i_op;
            r_imm     <= i_imm;
            r_rs1     <= i_rs1;
            r_rs2     <= i_rs2;
            r_pc_real <= i_pc - XLEN'(PC_OFFSET);
         end
         if (r_state == S_CMP) begin
            r_taken   <= w_cmp_taken;
            r_illegal <= w_cmp_illegal;
            r_target  <= r_pc_real + w_imm_sext;
         end
      end
   end

   always_comb begin
      w_next_state  = r_state;
      o_reg_ren_1   = 1'b0;
      o_reg_ren_2   = 1'b0;
      o_reg_raddr_1 = '0;
      o_reg_raddr_2 = '0;
      o_busy        = 1'b0;
      o_done        = 1'b0;
      o_pc_write    = 1'b0;
      o_pc_wdata    = '0;
      o_flush_cnt   = '0;
      o_illegal_op  = 1'b0;
      o_misalign    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) w_next_state = S_READ;
         end
         S_READ: begin
            o_busy        = 1'b1;
            o_reg_ren_1   = 1'b1;
            o_reg_ren_2   = 1'b1;
            o_reg_raddr_1 = r_rs1;
            o_reg_raddr_2 = r_rs2;
            w_next_state  = S_CMP;
         end
         S_CMP: begin
            o_busy       = 1'b1;
            w_next_state = S_RESOLVE;
         end
         S_RESOLVE: begin
            o_busy       = 1'b1;
            o_done       = 1'b1;
            o_illegal_op = r_illegal;
            w_next_state = S_IDLE;
            if (w_misalign) begin
               o_misalign = 1'b1;
            end else if (r_taken) begin
               if (w_near) begin
                  o_flush_cnt = FLUSH_W'((w_dist >> 2) - XLEN'(1));
               end else begin
                  o_pc_write  = 1'b1;
                  o_pc_wdata  = r_target;
                  o_flush_cnt = FLUSH_W'(FLUSH_MAX);
               end
            end
         end
         default: w_next_state = S_IDLE;
      endcase
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] r_taken_cnt, r_not_taken_cnt;

   // Illegal ops are never counted; misaligned taken branches are.
   always_ff @(posedge hclk or negedge hrstn) begin
      if (!hrstn) begin
         r_taken_cnt     <= '0;
         r_not_taken_cnt <= '0;
      end else if (r_state == S_RESOLVE && !r_illegal) begin
         if (r_taken) begin
            if (r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + 32'd1;
         end else begin
            if (r_not_taken_cnt != '1) r_not_taken_cnt <= r_not_taken_cnt + 32'd1;
         end
      end
   end

   assign o_taken_cnt     = r_taken_cnt;
   assign o_not_taken_cnt = r_not_taken_cnt;
`else
   assign o_taken_cnt     = '0;
   assign o_not_taken_cnt = '0;
`endif

endmodule

// File: tb/tb_exu_branch_unit.sv
// Self-checking bench for exu_branch_unit: directed corner cases plus random
// branches compared against a spec-level reference model.
module tb_exu_branch_unit;

   localparam int XLEN      = 32;
   localparam int PC_OFFSET = 8;
   localparam int FLUSH_MAX = 2;
`ifdef BRANCH_STATS_EN
   localparam bit STATS_EN = 1'b1;
`else
   localparam bit STATS_EN = 1'b0;
`endif

   logic            hclk, hrstn;
   logic            i_start;
   logic [2:0]      i_op;
   logic [12:0]     i_imm;
   logic [4:0]      i_rs1, i_rs2;
   logic [31:0]     i_pc;
   logic            o_reg_ren_1, o_reg_ren_2;
   logic [4:0]      o_reg_raddr_1, o_reg_raddr_2;
   logic [31:0]     i_reg_rdata_1, i_reg_rdata_2;
   logic            o_busy, o_done, o_pc_write;
   logic [31:0]     o_pc_wdata;
   logic [2:0]      o_flush_cnt;
   logic            o_illegal_op, o_misalign;
   logic [31:0]     o_taken_cnt, o_not_taken_cnt;

   logic [31:0]     rf [32];
   int              n_cmp, n_fail;
   int unsigned     cnt_t, cnt_nt;

   typedef struct {
      bit          taken;
      bit          illegal;
      bit          pc_write;
      bit          misalign;
      logic [31:0] wdata;
      int          flush;
   } res_t;

   exu_branch_unit #(.XLEN(XLEN), .PC_OFFSET(PC_OFFSET), .FLUSH_MAX(FLUSH_MAX)) dut (
      .hclk            (hclk),
      .hrstn           (hrstn),
      .i_start         (i_start),
      .i_op            (i_op),
      .i_imm           (i_imm),
      .i_rs1           (i_rs1),
      .i_rs2           (i_rs2),
      .i_pc            (i_pc),
      .o_reg_ren_1     (o_reg_ren_1),
      .o_reg_ren_2     (o_reg_ren_2),
      .o_reg_raddr_1   (o_reg_raddr_1),
      .o_reg_raddr_2   (o_reg_raddr_2),
      .i_reg_rdata_1   (i_reg_rdata_1),
      .i_reg_rdata_2   (i_reg_rdata_2),
      .o_busy          (o_busy),
      .o_done          (o_done),
      .o_pc_write      (o_pc_write),
      .o_pc_wdata      (o_pc_wdata),
      .o_flush_cnt     (o_flush_cnt),
      .o_illegal_op    (o_illegal_op),
      .o_misalign      (o_misalign),
      .o_taken_cnt     (o_taken_cnt),
      .o_not_taken_cnt (o_not_taken_cnt)
   );

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   // Register file: data appears the cycle after the read enable.
   always @(posedge hclk) begin
      if (o_reg_ren_1) i_reg_rdata_1 <= rf[o_reg_raddr_1];
      if (o_reg_ren_2) i_reg_rdata_2 <= rf[o_reg_raddr_2];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic res_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  input logic [12:0] imm, input logic [31:0] pc);
      res_t        r;
      int          off;
      longint      sa, sb, ua, ub;
      logic [31:0] target;
      r.taken = 0; r.illegal = 0; r.pc_write = 0; r.misalign = 0; r.wdata = '0; r.flush = 0;
      off    = $signed(imm);
      sa     = $signed(a);
      sb     = $signed(b);
      ua     = {32'd0, a};
      ub     = {32'd0, b};
      target = pc - 32'(PC_OFFSET) + 32'(off);
      case (op)
         3'b000:  r.taken = (a == b);
         3'b001:  r.taken = (a != b);
         3'b100:  r.taken = (sa <  sb);
         3'b101:  r.taken = (sa >= sb);
         3'b110:  r.taken = (ua <  ub);
         3'b111:  r.taken = (ua >= ub);
         default: r.illegal = 1;
      endcase
      if (r.taken) begin
         if (target[1]) r.misalign = 1;
         else if (off > 0 && off % 4 == 0 && off / 4 <= FLUSH_MAX) r.flush = off / 4 - 1;
         else begin
            r.pc_write = 1;
            r.wdata    = target;
            r.flush    = FLUSH_MAX;
         end
      end
      return r;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "/done"},     32'(o_done),          32'(0));
      check({tag, "/busy"},     32'(o_busy),          32'(0));
      check({tag, "/pc_write"}, 32'(o_pc_write),      32'(0));
      check({tag, "/pc_wdata"}, 32'(o_pc_wdata),      32'(0));
      check({tag, "/flush"},    32'(o_flush_cnt),     32'(0));
      check({tag, "/illegal"},  32'(o_illegal_op),    32'(0));
      check({tag, "/misalign"}, 32'(o_misalign),      32'(0));
      check({tag, "/ren1"},     32'(o_reg_ren_1),     32'(0));
      check({tag, "/ren2"},     32'(o_reg_ren_2),     32'(0));
      check({tag, "/raddr1"},   32'(o_reg_raddr_1),   32'(0));
      check({tag, "/raddr2"},   32'(o_reg_raddr_2),   32'(0));
      check({tag, "/tcnt"},     32'(o_taken_cnt),     32'(0));
      check({tag, "/ntcnt"},    32'(o_not_taken_cnt), 32'(0));
   endtask

   // One branch, start to done; hold keeps start high and scrambles inputs while busy.
   task automatic do_branch(input string tag, input logic [2:0] op, input logic [12:0] imm,
                            input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [31:0] pc, input bit hold);
      res_t e;
      e = model(op, rf[rs1], rf[rs2], imm, pc);
      @(negedge hclk);
      i_start = 1'b1; i_op = op; i_imm = imm; i_rs1 = rs1; i_rs2 = rs2; i_pc = pc;
      @(negedge hclk);
      if (hold) begin
         i_op = ~op; i_imm = ~imm; i_rs1 = ~rs1; i_rs2 = ~rs2; i_pc = ~pc;
      end else begin
         i_start = 1'b0;
      end
      check({tag, "/rd_ren1"},   32'(o_reg_ren_1),   32'(1));
      check({tag, "/rd_ren2"},   32'(o_reg_ren_2),   32'(1));
      check({tag, "/rd_raddr1"}, 32'(o_reg_raddr_1), 32'(rs1));
      check({tag, "/rd_raddr2"}, 32'(o_reg_raddr_2), 32'(rs2));
      check({tag, "/rd_busy"},   32'(o_busy),        32'(1));
      check({tag, "/rd_done"},   32'(o_done),        32'(0));
      @(negedge hclk);
      check({tag, "/cmp_ren1"},   32'(o_reg_ren_1),   32'(0));
      check({tag, "/cmp_raddr1"}, 32'(o_reg_raddr_1), 32'(0));
      check({tag, "/cmp_done"},   32'(o_done),        32'(0));
      check({tag, "/cmp_pcw"},    32'(o_pc_write),    32'(0));
      check({tag, "/cmp_busy"},   32'(o_busy),        32'(1));
      @(negedge hclk);
      check({tag, "/done"},     32'(o_done),       32'(1));
      check({tag, "/pc_write"}, 32'(o_pc_write),   32'(e.pc_write));
      check({tag, "/pc_wdata"}, 32'(o_pc_wdata),   32'(e.wdata));
      check({tag, "/flush"},    32'(o_flush_cnt),  32'(e.flush));
      check({tag, "/illegal"},  32'(o_illegal_op), 32'(e.illegal));
      check({tag, "/misalign"}, 32'(o_misalign),   32'(e.misalign));
      check({tag, "/res_ren2"}, 32'(o_reg_ren_2),  32'(0));
      i_start = 1'b0;
      if (!e.illegal) begin
         if (e.taken) cnt_t++;
         else         cnt_nt++;
      end
      @(negedge hclk);
      check({tag, "/post_done"},  32'(o_done),          32'(0));
      check({tag, "/post_busy"},  32'(o_busy),          32'(0));
      check({tag, "/post_flush"}, 32'(o_flush_cnt),     32'(0));
      check({tag, "/post_pcw"},   32'(o_pc_write),      32'(0));
      check({tag, "/tcnt"},       32'(o_taken_cnt),     STATS_EN ? 32'(cnt_t)  : 32'(0));
      check({tag, "/ntcnt"},      32'(o_not_taken_cnt), STATS_EN ? 32'(cnt_nt) : 32'(0));
   endtask

   initial begin
      logic [31:0] rnd;
      logic [4:0]  rs1, rs2;
      logic [12:0] imm;
      n_cmp = 0; n_fail = 0; cnt_t = 0; cnt_nt = 0;
      for (int i = 0; i < 32; i++) rf[i] = '0;
      hrstn = 1'b0; i_start = 1'b0; i_op = '0; i_imm = '0; i_rs1 = '0; i_rs2 = '0; i_pc = '0;
      i_reg_rdata_1 = '0; i_reg_rdata_2 = '0;
      #12;
      check_idle("reset");
      @(negedge hclk);
      hrstn = 1'b1;
      @(negedge hclk);
      check_idle("idle");

      rf[1] = 32'd5; rf[2] = 32'd5; rf[3] = 32'hFFFF_FFFF; rf[4] = 32'd1;
      do_branch("beq_far",   3'b000, 13'h010,  5'd1, 5'd2, 32'h108, 1'b0);
      do_branch("blt_neg",   3'b100, 13'h008,  5'd3, 5'd4, 32'h108, 1'b0);
      do_branch("bltu_neg",  3'b110, 13'h008,  5'd3, 5'd4, 32'h108, 1'b0);
      do_branch("bne_eq",    3'b001, 13'h010,  5'd1, 5'd2, 32'h108, 1'b0);
      do_branch("illegal2",  3'b010, 13'h010,  5'd1, 5'd2, 32'h108, 1'b0);
      do_branch("illegal3",  3'b011, 13'h004,  5'd1, 5'd2, 32'h108, 1'b0);
      do_branch("bge_mis",   3'b101, 13'h006,  5'd4, 5'd3, 32'h108, 1'b1);
      for (int k = 0; k < 4; k++) begin
         @(negedge hclk);
         check("hold_extra_done", 32'(o_done), 32'(0));
         check("hold_extra_busy", 32'(o_busy), 32'(0));
      end
      do_branch("beq_d4",    3'b000, 13'h004,  5'd1, 5'd2, 32'h200, 1'b0);
      do_branch("beq_d0",    3'b000, 13'h000,  5'd1, 5'd2, 32'h200, 1'b0);
      do_branch("beq_back",  3'b000, 13'h1FF8, 5'd1, 5'd2, 32'h008, 1'b0);
      do_branch("bgeu_eq",   3'b111, 13'h00C,  5'd1, 5'd2, 32'h300, 1'b0);
      do_branch("beq_wrap",  3'b000, 13'h1FFC, 5'd1, 5'd2, 32'h004, 1'b0);

      // Reset asserted while the comparison is in flight.
      @(negedge hclk);
      i_start = 1'b1; i_op = 3'b000; i_imm = 13'h040; i_rs1 = 5'd1; i_rs2 = 5'd2; i_pc = 32'h400;
      @(negedge hclk);
      i_start = 1'b0;
      @(negedge hclk);
      hrstn = 1'b0;
      cnt_t = 0; cnt_nt = 0;
      #1;
      check_idle("rst_cmp");
      for (int k = 0; k < 3; k++) begin
         @(negedge hclk);
         check("rst_hold_done", 32'(o_done),     32'(0));
         check("rst_hold_pcw",  32'(o_pc_write), 32'(0));
      end
      hrstn = 1'b1;
      @(negedge hclk);
      check_idle("rst_after");
      do_branch("post_rst",  3'b000, 13'h040,  5'd1, 5'd2, 32'h400, 1'b0);

      for (int n = 0; n < 40; n++) begin
         rs1 = 5'($urandom_range(1, 31));
         rs2 = 5'($urandom_range(1, 31));
         rf[rs1] = $urandom;
         rf[rs2] = ($urandom_range(0, 3) == 0) ? rf[rs1] : $urandom;
         if ($urandom_range(0, 1) == 0) begin
            imm = 13'(2 * $urandom_range(0, 10));
            if ($urandom_range(0, 3) == 0) imm = -imm;
         end else begin
            imm = 13'($urandom) & 13'h1FFE;
         end
         rnd = $urandom;
         do_branch("rand", 3'($urandom_range(0, 7)), imm, rs1, rs2, rnd & 32'hFFFF_FFFC,
                   1'($urandom_range(0, 1)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/exu_branch_unit.md
EXU_BRANCH_UNIT -- requirements
Module: exu_branch_unit

Interface
REQ-001 Parameter XLEN, default 32, data/PC width.
REQ-002 Parameter PC_OFFSET, default 8, amount the incoming pc has already advanced past the branch.
REQ-003 Parameter FLUSH_MAX, default 2, maximum pipeline stages flushed, range 1..7.
REQ-004 hclk  in  1  clock; hrstn  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  one-cycle request to execute a branch.
REQ-006 op  in  3  condition: BEQ 000, BNE 001, BLT 100, BGE 101, BLTU 110, BGEU 111; 010/011 illegal.
REQ-007 imm  in  13  B-type byte offset, bit 0 zero, sign-extended to XLEN.
REQ-008 rs1, rs2  in  5 each  source register indices.
REQ-009 pc  in  XLEN  current fetch PC.
REQ-010 reg_ren_1, reg_ren_2  out  1  regfile read enables; reg_raddr_1, reg_raddr_2  out  5  read addresses.
REQ-011 reg_rdata_1, reg_rdata_2  in  XLEN  read data, valid the cycle after enable.
REQ-012 busy  out  1  high from accept until done; done  out  1  one-cycle completion pulse.
REQ-013 pc_write  out  1; pc_wdata  out  XLEN  redirect request and target.
REQ-014 flush_cnt  out  3  stages to flush, valid with done.
REQ-015 illegal_op, misalign  out  1  error pulses, valid with done.
REQ-016 taken_cnt, not_taken_cnt  out  32  statistics counters.

Function
REQ-017 FSM states IDLE, READ, CMP, RESOLVE; IDLE->READ on start, READ->CMP, CMP->RESOLVE, RESOLVE->IDLE, each transition unconditional after the first.
REQ-018 In IDLE with start=1 the block shall capture op, imm, rs1, rs2 and pc_real = pc - PC_OFFSET (modulo 2^XLEN).
REQ-019 start shall be ignored while busy=1.
REQ-020 In READ reg_ren_1/2 shall be 1 and raddr shall equal the captured rs1/rs2; in all other states ren=0 and raddr=0.
REQ-021 In CMP the block shall register taken (signed/unsigned comparison per op) and target = pc_real + sext(imm).
REQ-022 In RESOLVE done=1 for exactly one cycle; total latency from start to done is 3 cycles.
REQ-023 Taken with d = target - pc_real = 4*(j+1), 0<=j<FLUSH_MAX: flush_cnt=j, pc_write=0.
REQ-024 Taken with any other d, including backward and zero offsets: flush_cnt=FLUSH_MAX, pc_write=1, pc_wdata=target.
REQ-025 Not taken: flush_cnt=0, pc_write=0, pc_wdata=0.
REQ-026 Illegal op: illegal_op=1, treated as not taken, not counted.
REQ-027 Taken with target[1]=1: misalign=1, no redirect, flush_cnt=0.
REQ-028 pc_write, pc_wdata, flush_cnt, illegal_op and misalign shall be 0 outside RESOLVE.

Reset
REQ-029 On hrstn low: state IDLE; all outputs 0; counters 0; captured fields 0.
REQ-030 Reset mid-operation shall abort without emitting done or pc_write.

Configuration
REQ-031 With BRANCH_STATS_EN defined: at done, taken_cnt increments on a taken legal branch (misaligned included) and not_taken_cnt on a not-taken legal branch; both saturate at 0xFFFFFFFF.
REQ-032 Without BRANCH_STATS_EN: the counters are not implemented and both outputs are constant 0.

Structure
REQ-033 Package exu_branch_pkg shall hold the op encodings, the FSM state enum and the flush_cnt width constant.
REQ-034 Sub-module branch_cmp shall hold the combinational condition evaluation (op, a, b -> taken, illegal).

Verification
REQ-035 BEQ, x1=x2=5, pc=0x108, imm=0x10 -> done at cycle 3, pc_write=1, pc_wdata=0x110, flush_cnt=2.
REQ-036 BLT, rs1=0xFFFFFFFF, rs2=1, imm=8, pc=0x108 -> taken, flush_cnt=1, pc_write=0; BLTU with the same operands -> not taken, flush_cnt=0.
REQ-037 BNE, equal operands -> pc_write=0, flush_cnt=0, not_taken_cnt +1 with BRANCH_STATS_EN.
REQ-038 op=010 -> illegal_op pulse with done, no redirect, counters unchanged.
REQ-039 BGE taken, imm=6 -> misalign=1, pc_write=0; a second start asserted during busy -> ignored, exactly one done.
REQ-040 hrstn low during CMP -> no done, no pc_write, outputs 0; the next start completes normally.
